// File: rtl/ring_sched_pkg.sv
// rtl/ring_sched_pkg.sv - shared op codes, state encoding and default sizes for the ring scheduler
package ring_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 16;

    localparam logic [1:0] OP_NONE   = 2'd0;
    localparam logic [1:0] OP_PUSH   = 2'd1;
    localparam logic [1:0] OP_ROTATE = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter; index 0 is favoured after reset
module rr_arb2 (
    input  logic       clk,
    input  logic       async_reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_gnt holds the index of the most recent grant
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/ring_op_scheduler.sv
// rtl/ring_op_scheduler.sv - push/rotate arbitration and timed scan sequencing for the digit ring
// Optional scan abort input is enabled by defining RING_SCAN_ABORT_EN.
module ring_op_scheduler
    import ring_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic                       push_req,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ack,
    input  logic                       rot_req,
    output logic                       rot_ack,
    input  logic                       scan_start,
    input  logic                       tick,
`ifdef RING_SCAN_ABORT_EN
    input  logic                       scan_abort,
`endif
    output logic                       scan_busy,
    output logic                       scan_done,
    output logic                       op_valid,
    output logic [1:0]                 op_code,
    output logic [WIDTH-1:0]           op_data,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_t            state, state_n;
    logic [CW-1:0]     step, step_n;
    logic [CW-1:0]     fill_n;
    logic [1:0]        code_n;
    logic [WIDTH-1:0]  data_n;
    logic              push_ack_n, rot_ack_n, done_n, busy_n;
    logic              abort;
    logic              arb_en;
    logic [1:0]        arb_req, gnt;

`ifdef RING_SCAN_ABORT_EN
    assign abort = scan_abort;
`else
    assign abort = 1'b0;
`endif

    // A requester still showing its ack is masked so a held level cannot win twice
    assign arb_en  = (state == ST_IDLE) && !scan_start;
    assign arb_req = {rot_req & ~rot_ack, push_req & ~push_ack};

    rr_arb2 u_arb (
        .clk         (clk),
        .async_reset (async_reset),
        .en          (arb_en),
        .req         (arb_req),
        .gnt         (gnt)
    );

    always_comb begin
        state_n    = state;
        step_n     = step;
        fill_n     = fill_count;
        code_n     = OP_NONE;
        data_n     = '0;
        push_ack_n = 1'b0;
        rot_ack_n  = 1'b0;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scan_start) begin
                    state_n = ST_SCAN;
                    step_n  = '0;
                end else if (gnt[0]) begin
                    code_n     = OP_PUSH;
                    data_n     = push_data;
                    push_ack_n = 1'b1;
                    if (fill_count != FULL) begin
                        fill_n = fill_count + 1'b1;
                    end
                end else if (gnt[1]) begin
                    code_n    = OP_ROTATE;
                    rot_ack_n = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (tick) begin
                    code_n = OP_ROTATE;
                    step_n = step + 1'b1;
                    if (step == LAST) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // busy covers the scan plus the cycle carrying the final rotate
        busy_n = (state_n == ST_SCAN) || (state == ST_SCAN);
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state      <= ST_IDLE;
            step       <= '0;
            fill_count <= '0;
            op_valid   <= 1'b0;
            op_code    <= OP_NONE;
            op_data    <= '0;
            push_ack   <= 1'b0;
            rot_ack    <= 1'b0;
            scan_done  <= 1'b0;
            scan_busy  <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            fill_count <= fill_n;
            op_valid   <= (code_n != OP_NONE);
            op_code    <= code_n;
            op_data    <= data_n;
            push_ack   <= push_ack_n;
            rot_ack    <= rot_ack_n;
            scan_done  <= done_n;
            scan_busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_ring_op_scheduler.sv
// tb/tb_ring_op_scheduler.sv - randomized scoreboard bench for ring_op_scheduler
module tb_ring_op_scheduler;

    localparam int W = 4;
    localparam int D = 16;

    logic         clk;
    logic         async_reset;
    logic         push_req;
    logic [W-1:0] push_data;
    logic         push_ack;
    logic         rot_req;
    logic         rot_ack;
    logic         scan_start;
    logic         tick;
    logic         scan_abort;
    logic         scan_busy;
    logic         scan_done;
    logic         op_valid;
    logic [1:0]   op_code;
    logic [W-1:0] op_data;
    logic [4:0]   fill_count;

    ring_op_scheduler #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .push_req    (push_req),
        .push_data   (push_data),
        .push_ack    (push_ack),
        .rot_req     (rot_req),
        .rot_ack     (rot_ack),
        .scan_start  (scan_start),
        .tick        (tick),
`ifdef RING_SCAN_ABORT_EN
        .scan_abort  (scan_abort),
`endif
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_data     (op_data),
        .fill_count  (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       done;
        logic [1:0] code;
        logic [3:0] data;
        logic [4:0] fill;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   fill_m = 0;
    int   last_m = 1;   // 0: push granted last, 1: rotate granted last

    function automatic void chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void exp_push(input logic [3:0] d);
        if (fill_m < D) fill_m++;
        q.push_back('{done: 1'b0, code: 2'd1, data: d, fill: 5'(fill_m)});
        last_m = 0;
    endfunction

    function automatic void exp_rot();
        q.push_back('{done: 1'b0, code: 2'd2, data: 4'd0, fill: 5'(fill_m)});
        last_m = 1;
    endfunction

    function automatic void exp_scan_rot(input bit last);
        q.push_back('{done: last, code: 2'd2, data: 4'd0, fill: 5'(fill_m)});
    endfunction

    // Monitor: every cycle, either an op matches the scoreboard head or all op outputs are quiet
    always @(negedge clk) begin
        exp_t e;
        chk("two_acks", int'(push_ack && rot_ack), 0);
        if (op_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_op_valid", int'(op_valid), 0);
            end else begin
                e = q.pop_front();
                chk("op_code", int'(op_code), int'(e.code));
                chk("op_data", int'(op_data), int'(e.data));
                chk("scan_done", int'(scan_done), int'(e.done));
                chk("fill_count", int'(fill_count), int'(e.fill));
                chk("push_ack", int'(push_ack), int'(e.code == 2'd1 && !e.done && e.data == op_data && 1'b1) & int'(e.code == 2'd1));
                chk("rot_ack", int'(rot_ack), int'(e.code == 2'd2 && !scan_busy));
            end
        end else begin
            chk("idle_outputs", int'({op_code, op_data, push_ack, rot_ack, scan_done}), 0);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 async_reset = 1'b1;
        #1;
        chk("rst_op_valid", int'(op_valid), 0);
        chk("rst_op_code", int'(op_code), 0);
        chk("rst_fill", int'(fill_count), 0);
        chk("rst_busy", int'(scan_busy), 0);
        chk("rst_acks", int'({push_ack, rot_ack, scan_done}), 0);
        q.delete();
        fill_m = 0;
        last_m = 1;
        push_req = 1'b0; rot_req = 1'b0; scan_start = 1'b0; tick = 1'b0; scan_abort = 1'b0;
        @(negedge clk);
        async_reset = 1'b0;
    endtask

    task automatic wait_ack(input bit is_rot, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = is_rot ? rot_ack : push_ack;
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic do_push(input logic [3:0] d);
        @(negedge clk);
        push_req = 1'b1; push_data = d;
        exp_push(d);
        wait_ack(1'b0, "push_ack_seen");
        push_req = 1'b0;
    endtask

    task automatic do_rot();
        @(negedge clk);
        rot_req = 1'b1;
        exp_rot();
        wait_ack(1'b1, "rot_ack_seen");
        rot_req = 1'b0;
    endtask

    task automatic contention(input int k, input logic [3:0] d);
        @(negedge clk);
        push_req = 1'b1; rot_req = 1'b1; push_data = d;
        for (int i = 0; i < k; i++) begin
            if (last_m == 1) exp_push(d); else exp_rot();
        end
        repeat (k) @(posedge clk);
        @(negedge clk);
        push_req = 1'b0; rot_req = 1'b0;
    endtask

    // Starts a scan and runs nticks ticks; returns after the last tick's op is visible
    task automatic scan_ticks(input bit co_tick, input bit co_push, input bit co_rot,
                              input int nticks, input int gap);
        @(negedge clk);
        scan_start = 1'b1; tick = co_tick;
        if (co_push) begin push_req = 1'b1; push_data = 4'($urandom); end
        if (co_rot) rot_req = 1'b1;
        @(negedge clk);
        scan_start = 1'b0; tick = 1'b0;
        chk("scan_busy_on", int'(scan_busy), 1);
        for (int i = 0; i < nticks; i++) begin
            repeat (gap < 0 ? $urandom_range(0, 4) : gap) @(negedge clk);
            tick = 1'b1;
            exp_scan_rot(i == D - 1);
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic full_scan(input bit co_tick, input bit co_push, input bit co_rot, input int gap);
        bit p_pend = co_push;
        bit r_pend = co_rot;
        scan_ticks(co_tick, co_push, co_rot, D, gap);
        chk("scan_busy_at_done", int'(scan_busy), 1);
        if (co_push && co_rot) begin
            if (last_m == 1) begin exp_push(push_data); exp_rot(); end
            else begin exp_rot(); exp_push(push_data); end
        end else if (co_push) exp_push(push_data);
        else if (co_rot) exp_rot();
        @(negedge clk);
        chk("scan_busy_off", int'(scan_busy), 0);
        for (int i = 0; i < 50 && (p_pend || r_pend); i++) begin
            if (i > 0) @(negedge clk);
            if (p_pend && push_ack) begin push_req = 1'b0; p_pend = 1'b0; end
            if (r_pend && rot_ack) begin rot_req = 1'b0; r_pend = 1'b0; end
        end
        chk("pending_granted", int'(p_pend || r_pend), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected %0d", 0);
        $fatal(1, "watchdog");
    end

    initial begin
        async_reset = 1'b1;
        push_req = 1'b0; push_data = '0; rot_req = 1'b0;
        scan_start = 1'b0; tick = 1'b0; scan_abort = 1'b0;
        #1;
        chk("init_op_valid", int'(op_valid), 0);
        chk("init_fill", int'(fill_count), 0);
        repeat (2) @(negedge clk);
        async_reset = 1'b0;

        do_push(4'd7);
        chk("first_push_fill", int'(fill_count), 1);

        apply_reset();
        contention(4, 4'($urandom));

        for (int i = 0; i < 17; i++) do_push(4'($urandom));
        @(negedge clk);
        chk("fill_saturated", int'(fill_count), D);

        full_scan(1'b0, 1'b0, 1'b1, 5);
        full_scan(1'b1, 1'b1, 1'b0, 1);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: do_push(4'($urandom));
                1: do_rot();
                2: contention($urandom_range(1, 6), 4'($urandom));
                default: full_scan(1'($urandom), 1'($urandom), 1'($urandom), -1);
            endcase
        end

        scan_ticks(1'b0, 1'b0, 1'b0, 5, 2);
        repeat (2) @(negedge clk);
        apply_reset();
        chk("post_reset_busy", int'(scan_busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end

`ifdef RING_SCAN_ABORT_EN
        scan_ticks(1'b0, 1'b0, 1'b0, 3, 2);
        repeat (2) @(negedge clk);
        tick = 1'b1; scan_abort = 1'b1;
        @(negedge clk);
        tick = 1'b0; scan_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy_off", int'(scan_busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        do_push(4'd9);
`endif

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_op_scheduler.md
Name: ring_op_scheduler

Overview:
- Sequences every operation on the 16-entry, 4-bit digit register ring and shares it between two requesters: the switch-entry push path and the manual rotate button.
- Runs timed auto-scan sequences: one full ring rotation, one step per timer tick.
- Emits one registered operation per cycle; the ring bank decodes it into per-entry NONE/LOAD controls.

Parameters:
- WIDTH, 4, data width of one ring entry.
- DEPTH, 16, number of ring entries; also the number of steps in one scan.

Ports:
- clk  in  1  system clock, rising edge.
- async_reset  in  1  asynchronous, active-high reset.
- push_req  in  1  push request, level; held until push_ack.
- push_data  in  WIDTH  value to shift into entry 0; must be stable while push_req is high.
- push_ack  out  1  one-cycle grant pulse for the push requester.
- rot_req  in  1  rotate request, level; held until rot_ack.
- rot_ack  out  1  one-cycle grant pulse for the rotate requester.
- scan_start  in  1  one-cycle pulse; starts an auto-scan.
- tick  in  1  one-cycle pulse from the second timer.
- scan_busy  out  1  high while in SCAN.
- scan_done  out  1  one-cycle pulse when a scan completes.
- op_valid  out  1  high when op_code/op_data are meaningful this cycle.
- op_code  out  2  operation code: 0 NONE, 1 PUSH, 2 ROTATE.
- op_data  out  WIDTH  push value; zero unless op_code is PUSH.
- fill_count  out  $clog2(DEPTH+1)  number of pushes, saturating at DEPTH.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; step counter 0; round-robin pointer favours push. Reset mid-scan abandons the scan with no scan_done.
- All outputs are registered. A decision made at edge N appears in the cycle after edge N.
- Each ack pulse coincides with its op_valid cycle.
- States:
  - IDLE: accepts scan_start and push/rotate requests.
  - SCAN: issues timed rotations.
- Priority in IDLE, highest first:
  - scan_start → go to SCAN, clear step counter, issue no op.
  - Push/rotate requests → grant one per cycle.
- Two-way round-robin between push and rotate:
  - When both are requested, grant the requester not granted most recently.
  - A single request is always granted.
- A requester whose ack is high this cycle is ignored in the same-cycle arbitration decision. This prevents a double grant while the requester drops req.
- Push grant:
  - op_code = PUSH; op_data = push_data captured at the grant edge.
  - fill_count += 1, saturating at DEPTH.
- Rotate grant: op_code = ROTATE; fill_count unchanged.
- SCAN:
  - push_req and rot_req are stalled: no ack, requests stay pending.
  - scan_start is ignored.
  - Each tick → one ROTATE op and step counter += 1.
  - When a tick brings the counter to DEPTH → return to IDLE and pulse scan_done together with that final ROTATE.
  - scan_busy deasserts on the following cycle.
- A tick in IDLE is ignored.
- A tick in the same cycle as an accepted scan_start is ignored; the scan needs DEPTH subsequent ticks.
- Pending requests are granted starting the first cycle after the return to IDLE.
- op_valid = 0 and op_code = NONE whenever no op is issued.

Optional Feature:
- Macro RING_SCAN_ABORT_EN.
- When defined:
  - Adds input scan_abort (1 bit).
  - scan_abort high in SCAN → return to IDLE next cycle, no scan_done, no further ops. The ring is left partially rotated.
  - scan_abort has priority over a simultaneous tick.
  - scan_abort is ignored in IDLE.
- When undefined: no port; a scan always runs to completion.

Decomposition:
- Package ring_sched_pkg:
  - op code constants OP_NONE/OP_PUSH/OP_ROTATE (2-bit).
  - state encoding ST_IDLE/ST_SCAN.
  - default WIDTH/DEPTH.
- Sub-module rr_arb2: two-request round-robin arbiter with last-grant pointer. It has an enable input so SCAN can mask grants.

Test Plan:
- Reset: push_req=1 with push_data=4'd7, single request → push_ack=1, op_valid=1, op_code=1, op_data=7 one cycle after grant; fill_count=1.
- Contention: push_req and rot_req held together for 4 cycles → grants alternate PUSH, ROTATE, PUSH, ROTATE (push first after reset); no cycle has two acks.
- 17 single pushes → fill_count saturates at 16.
- scan_start, then 16 ticks spaced 5 cycles apart:
  - exactly 16 ROTATE ops, one per tick.
  - scan_done pulses with the 16th.
  - scan_busy drops the next cycle.
  - rot_req held throughout is acked only after return to IDLE.
- scan_start coincident with tick, and with push_req → no op that cycle; push stalled; scan needs 16 more ticks.
- async_reset asserted after 5 scan steps → all outputs 0 immediately, state IDLE, no scan_done.
- With RING_SCAN_ABORT_EN: abort after 3 ticks, coincident with a tick → no 4th ROTATE, no scan_done, IDLE next cycle.
